// File: rtl/color_ctrl.sv
// Frame-based command sequencer for colorGen: parses A5/CMD/payload/CSUM frames, commits
// validated settings in one cycle, and auto-steps the hue index at a programmable rate.
module color_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter logic [7:0]  IDX_MAX = 8'hD8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] mode_out,
  output logic [7:0] lint_out,
  output logic [7:0] idx_out,
  output logic [7:0] white_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out
);

  localparam int unsigned GapW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StPayload, StCsum, StCommit} state_e;

  state_e          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      csum_q, csum_d;
  logic [3:0][7:0] stg_q, stg_d;
  logic            err_q, err_d;
  logic [7:0]      mode_q, mode_d, lint_q, lint_d, idx_q, idx_d;
  logic [7:0]      white_q, white_d, red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic            auto_q, auto_d;
  logic [15:0]     rate_q, rate_d, rate_cnt_q, rate_cnt_d;
  logic            accept;

  assign rx_ready = (state_q != StCommit);
  assign busy     = (state_q != StIdle);
  assign accept   = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    gap_d      = gap_q;
    cmd_d      = cmd_q;
    csum_d     = csum_q;
    stg_d      = stg_q;
    err_d      = 1'b0;
    mode_d     = mode_q;
    lint_d     = lint_q;
    idx_d      = idx_q;
    white_d    = white_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    auto_d     = auto_q;
    rate_d     = rate_q;
    rate_cnt_d = rate_cnt_q;

    unique case (state_q)
      StIdle: begin
        gap_d = '0;
        if (accept && rx_data == 8'hA5) state_d = StCmd;
      end
      StCmd: if (accept) begin
        cmd_d  = rx_data;
        csum_d = rx_data;
        case (rx_data)
          8'h21:        begin pcnt_d = 3'd4; state_d = StPayload; end
          8'hA4, 8'hC3: begin pcnt_d = 3'd3; state_d = StPayload; end
          8'h0F:        state_d = StCsum;
          default:      begin err_d = 1'b1; state_d = StIdle; end
        endcase
      end
      StPayload: if (accept) begin
        // Shift staging so the last payload byte always lands in stg[0].
        stg_d  = {stg_q[2:0], rx_data};
        csum_d = csum_q ^ rx_data;
        pcnt_d = pcnt_q - 3'd1;
        if (pcnt_q == 3'd1) state_d = StCsum;
      end
      StCsum: if (accept) begin
        if (rx_data == csum_q) begin
          state_d = StCommit;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_q == StCmd || state_q == StPayload || state_q == StCsum) begin
      if (accept) begin
        gap_d = '0;
      end else if (gap_q == GapW'(TIMEOUT - 1)) begin
        gap_d   = '0;
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end

    // A commit takes the edge; any auto step due on it is dropped.
    if (state_q == StCommit) begin
      auto_d = 1'b0;
      case (cmd_q)
        8'h21: begin
          mode_d  = 8'h21;
          white_d = stg_q[3];
          red_d   = stg_q[2];
          green_d = stg_q[1];
          blue_d  = stg_q[0];
        end
        8'hA4: begin
          mode_d  = 8'hA4;
          idx_d   = stg_q[2];
          white_d = stg_q[1];
          lint_d  = stg_q[0];
        end
        8'hC3: begin
          mode_d     = 8'hA4;
          lint_d     = stg_q[0];
          auto_d     = 1'b1;
          rate_d     = {stg_q[2], stg_q[1]};
          rate_cnt_d = '0;
        end
        default: begin
          mode_d  = 8'h21;
          white_d = '0;
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
        end
      endcase
    end else if (auto_q) begin
      if (rate_cnt_q == rate_q) begin
        rate_cnt_d = '0;
        idx_d      = (idx_q >= IDX_MAX) ? 8'h00 : idx_q + 8'd1;
      end else begin
        rate_cnt_d = rate_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pcnt_q     <= '0;
      gap_q      <= '0;
      cmd_q      <= '0;
      csum_q     <= '0;
      stg_q      <= '0;
      err_q      <= 1'b0;
      mode_q     <= '0;
      lint_q     <= '0;
      idx_q      <= '0;
      white_q    <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      auto_q     <= 1'b0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      gap_q      <= gap_d;
      cmd_q      <= cmd_d;
      csum_q     <= csum_d;
      stg_q      <= stg_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      lint_q     <= lint_d;
      idx_q      <= idx_d;
      white_q    <= white_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      auto_q     <= auto_d;
      rate_q     <= rate_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end

  assign frame_err = err_q;
  assign mode_out  = mode_q;
  assign lint_out  = lint_q;
  assign idx_out   = idx_q;
  assign white_out = white_q;
  assign red_out   = red_q;
  assign green_out = green_q;
  assign blue_out  = blue_q;

endmodule

// File: tb/tb_color_ctrl.sv
// Self-checking bench for color_ctrl: a queue-based frame model checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_color_ctrl;
  localparam int unsigned TIMEOUT = 1024;
  localparam logic [7:0]  IDX_MAX = 8'hD8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready, busy, frame_err;
  logic [7:0] mode_out, lint_out, idx_out, white_out, red_out, green_out, blue_out;

  color_ctrl #(.TIMEOUT(TIMEOUT), .IDX_MAX(IDX_MAX)) dut (
    .clk(clk), .reset(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_err(frame_err), .mode_out(mode_out), .lint_out(lint_out),
    .idx_out(idx_out), .white_out(white_out), .red_out(red_out), .green_out(green_out),
    .blue_out(blue_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frames are collected as byte queues and judged whole.
  logic [7:0] m_mode = 0, m_lint = 0, m_idx = 0, m_w = 0, m_r = 0, m_g = 0, m_b = 0;
  logic       m_auto = 0, m_err = 0, m_commit = 0, m_inframe = 0;
  int         m_rate = 0, m_t = 0, m_idle = 0;
  logic [7:0] m_frame[$];
  logic [7:0] m_pend[$];

  function automatic int plen(input logic [7:0] c);
    case (c)
      8'h21:        return 4;
      8'hA4, 8'hC3: return 3;
      8'h0F:        return 0;
      default:      return -1;
    endcase
  endfunction

  task automatic model_apply();
    m_auto = 0;
    case (m_pend[0])
      8'h21: begin m_mode = 8'h21; m_w = m_pend[1]; m_r = m_pend[2]; m_g = m_pend[3];
                   m_b = m_pend[4]; end
      8'hA4: begin m_mode = 8'hA4; m_idx = m_pend[1]; m_w = m_pend[2]; m_lint = m_pend[3]; end
      8'hC3: begin m_mode = 8'hA4; m_lint = m_pend[3]; m_rate = {m_pend[1], m_pend[2]};
                   m_auto = 1; m_t = 0; end
      default: begin m_mode = 8'h21; m_w = 0; m_r = 0; m_g = 0; m_b = 0; end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_lint = 0; m_idx = 0; m_w = 0; m_r = 0; m_g = 0; m_b = 0;
      m_auto = 0; m_err = 0; m_commit = 0; m_inframe = 0; m_rate = 0; m_t = 0; m_idle = 0;
      m_frame.delete();
    end else begin
      logic was_commit;
      logic [7:0] x;
      was_commit = m_commit;
      m_err = 0;
      if (m_commit) begin
        model_apply();
        m_commit = 0;
      end else if (m_auto) begin
        m_t++;
        if (m_t % (m_rate + 1) == 0) m_idx = (m_idx >= IDX_MAX) ? 8'h00 : m_idx + 8'd1;
      end
      if (!was_commit) begin
        if (rx_valid) begin
          if (!m_inframe) begin
            if (rx_data == 8'hA5) begin m_inframe = 1; m_frame.delete(); m_idle = 0; end
          end else begin
            m_frame.push_back(rx_data);
            m_idle = 0;
            if (plen(m_frame[0]) < 0) begin
              m_err = 1; m_inframe = 0;
            end else if (m_frame.size() == plen(m_frame[0]) + 2) begin
              x = 8'h00;
              foreach (m_frame[i]) x = x ^ m_frame[i];
              if (x == 8'h00) begin m_pend = m_frame; m_commit = 1; end
              else m_err = 1;
              m_inframe = 0;
            end
          end
        end else if (m_inframe) begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_err = 1; m_inframe = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rx_ready", 32'(rx_ready), 32'(!m_commit));
      chk("busy", 32'(busy), 32'(m_inframe || m_commit));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("mode_out", 32'(mode_out), 32'(m_mode));
      chk("lint_out", 32'(lint_out), 32'(m_lint));
      chk("idx_out", 32'(idx_out), 32'(m_idx));
      chk("white_out", 32'(white_out), 32'(m_w));
      chk("red_out", 32'(red_out), 32'(m_r));
      chk("green_out", 32'(green_out), 32'(m_g));
      chk("blue_out", 32'(blue_out), 32'(m_b));
    end
  end

  logic [7:0] tx[$];

  task automatic send();
    foreach (tx[i]) begin
      rx_valid = 1'b1;
      rx_data  = tx[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_chan(input string tag, input logic [7:0] w, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
    chk({tag, " white"}, 32'(white_out), 32'(w));
    chk({tag, " red"}, 32'(red_out), 32'(r));
    chk({tag, " green"}, 32'(green_out), 32'(g));
    chk({tag, " blue"}, 32'(blue_out), 32'(b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    idle(3);
    chk("reset mode", 32'(mode_out), 32'h00);
    chk("reset idx", 32'(idx_out), 32'h00);
    chk("reset rx_ready", 32'(rx_ready), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk_chan("reset", 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    idle(1);

    // 1: direct frame; outputs appear two edges after CSUM
    tx = '{8'hA5, 8'h21, 8'h10, 8'h20, 8'h30, 8'h40, 8'h61};
    send();
    chk("s1 pre-commit mode", 32'(mode_out), 32'h00);
    chk("s1 commit rx_ready", 32'(rx_ready), 32'h0);
    idle(1);
    chk("s1 mode", 32'(mode_out), 32'h21);
    chk_chan("s1", 8'h10, 8'h20, 8'h30, 8'h40);

    // 2: bad checksum
    tx = '{8'hA5, 8'hA4, 8'h48, 8'h05, 8'h20, 8'h00};
    send();
    chk("s2 frame_err", 32'(frame_err), 32'h1);
    chk("s2 busy", 32'(busy), 32'h0);
    idle(1);
    chk("s2 frame_err pulse", 32'(frame_err), 32'h0);
    chk("s2 mode", 32'(mode_out), 32'h21);
    chk_chan("s2", 8'h10, 8'h20, 8'h30, 8'h40);

    // 3: hue frame
    tx = '{8'hA5, 8'hA4, 8'h48, 8'h05, 8'h20, 8'hC9};
    send();
    idle(1);
    chk("s3 mode", 32'(mode_out), 32'hA4);
    chk("s3 idx", 32'(idx_out), 32'h48);
    chk("s3 lint", 32'(lint_out), 32'h20);
    chk_chan("s3", 8'h05, 8'h20, 8'h30, 8'h40);

    // 4: auto-cycle from D7 with rate 3, then off (commit collides with a due step)
    tx = '{8'hA5, 8'hA4, 8'hD7, 8'h05, 8'h20, 8'h56};
    send();
    idle(1);
    chk("s4 idx start", 32'(idx_out), 32'hD7);
    tx = '{8'hA5, 8'hC3, 8'h00, 8'h03, 8'h00, 8'hC0};
    send();
    idle(1);
    chk("s4 auto mode", 32'(mode_out), 32'hA4);
    idle(3);
    chk("s4 idx hold", 32'(idx_out), 32'hD7);
    idle(1);
    chk("s4 idx D8", 32'(idx_out), 32'hD8);
    idle(4);
    chk("s4 idx wrap", 32'(idx_out), 32'h00);
    idle(4);
    chk("s4 idx 01", 32'(idx_out), 32'h01);
    tx = '{8'hA5, 8'h0F, 8'h0F};
    send();
    idle(1);
    chk("s4 off mode", 32'(mode_out), 32'h21);
    chk("s4 off idx", 32'(idx_out), 32'h01);
    chk_chan("s4 off", 8'h00, 8'h00, 8'h00, 8'h00);
    idle(10);
    chk("s4 frozen idx", 32'(idx_out), 32'h01);

    // 5: garbage, then timeout, then a frame full of A5 payload bytes
    tx = '{8'h00, 8'hFF, 8'h33};
    send();
    chk("s5 garbage busy", 32'(busy), 32'h0);
    tx = '{8'hA5, 8'h21, 8'h10};
    send();
    k = 0;
    for (int i = 1; i <= 1100; i++) begin
      idle(1);
      if (frame_err) begin k = i; break; end
    end
    chk("s5 timeout cycles", 32'(k), 32'(TIMEOUT));
    chk("s5 timeout busy", 32'(busy), 32'h0);
    idle(1);
    tx = '{8'hA5, 8'h21, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h21};
    send();
    idle(1);
    chk("s5 mode", 32'(mode_out), 32'h21);
    chk_chan("s5", 8'hA5, 8'hA5, 8'hA5, 8'hA5);

    // 6: asynchronous reset mid-payload
    tx = '{8'hA5, 8'h21, 8'h11, 8'h22};
    send();
    #2 rst_n = 1'b0;
    #1;
    chk("s6 async mode", 32'(mode_out), 32'h00);
    chk("s6 async lint", 32'(lint_out), 32'h00);
    chk("s6 async idx", 32'(idx_out), 32'h00);
    chk("s6 async busy", 32'(busy), 32'h0);
    chk("s6 async rx_ready", 32'(rx_ready), 32'h1);
    chk_chan("s6 async", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    tx = '{8'hA5, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04, 8'h25};
    send();
    idle(1);
    chk("s6 mode", 32'(mode_out), 32'h21);
    chk_chan("s6", 8'h01, 8'h02, 8'h03, 8'h04);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
